// File: rtl/vpg_mode_ctrl.sv
// Pushbutton front end for the video pattern generator: synchronises and debounces
// the mode and colour keys, sequences mode steps with a reconfiguration hold-off.

module vpg_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_100,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic          deb, deb_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= 2'b11;
      deb   <= 1'b1;
      deb_d <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      deb_d <= deb;
      // one pulse per press, the cycle after the debounced level falls
      press <= deb_d & ~deb;
      if (sync[1] == deb) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        deb <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module vpg_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLDOFF_CYCLES  = 20000000,
  parameter int NUM_MODES       = 6,
  parameter int INIT_MODE       = 0
) (
  input  logic       clk_100,
  input  logic       reset_n,
  input  logic       key_mode_n,
  input  logic       key_color_n,
  output logic [3:0] mode,
  output logic       mode_change,
  output logic [1:0] disp_color,
  output logic       busy
);
  localparam int NUM_KEYS = 2;
  localparam int HW       = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, PULSE, HOLDOFF} state_t;

  logic [NUM_KEYS-1:0] key_n, press;
  state_t              state, state_nxt;
  logic [HW-1:0]       hcnt, hcnt_nxt;
  logic [3:0]          mode_nxt;

  assign key_n = {key_color_n, key_mode_n};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    vpg_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk_100 (clk_100),
      .reset_n (reset_n),
      .key_n   (key_n[k]),
      .press   (press[k])
    );
  end

  // Reset lands in HOLDOFF: the generator latches mode on its own reset, so no pulse.
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HOLDOFF;
      hcnt       <= HW'(HOLDOFF_CYCLES - 1);
      mode       <= 4'(INIT_MODE);
      disp_color <= 2'd0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      mode  <= mode_nxt;
      if (press[1]) disp_color <= disp_color + 2'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    hcnt_nxt    = hcnt;
    mode_nxt    = mode;
    mode_change = 1'b0;
    case (state)
      IDLE: if (press[0]) begin
        state_nxt = LOAD;
        mode_nxt  = (mode == 4'(NUM_MODES - 1)) ? 4'd0 : mode + 4'd1;
      end
      LOAD: state_nxt = PULSE;
      PULSE: begin
        mode_change = 1'b1;
        state_nxt   = HOLDOFF;
        hcnt_nxt    = HW'(HOLDOFF_CYCLES - 1);
      end
      HOLDOFF: begin
        if (hcnt == '0) state_nxt = IDLE;
        else            hcnt_nxt  = hcnt - HW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
endmodule
